// File: rtl/coin_acceptor_if.sv
// Coin acceptor handshake bundle: coin/cancel inputs from the user side,
// controller status inputs, and paid/change/reject/busy/credit outputs.
interface coin_acceptor_if #(
  parameter int CREDIT_W = 5
);
  logic                i_coin_1;
  logic                i_coin_2;
  logic                i_coin_5;
  logic                i_cancel;
  logic                i_coinreturn;
  logic                i_cycle_done;
  logic                o_coin;
  logic                o_change;
  logic                o_reject;
  logic                o_busy;
  logic [CREDIT_W-1:0] o_credit;

  modport master (
    output i_coin_1,
    output i_coin_2,
    output i_coin_5,
    output i_cancel,
    output i_coinreturn,
    output i_cycle_done,
    input  o_coin,
    input  o_change,
    input  o_reject,
    input  o_busy,
    input  o_credit
  );

  modport slave (
    input  i_coin_1,
    input  i_coin_2,
    input  i_coin_5,
    input  i_cancel,
    input  i_coinreturn,
    input  i_cycle_done,
    output o_coin,
    output o_change,
    output o_reject,
    output o_busy,
    output o_credit
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: collects 1/2/5 coins up to PRICE, returns change,
// holds paid level until wash done, refunds on cancel or coin return.
// Ports: i_clk, i_rst (async, active-high), bus (coin_acceptor_if.slave).
module coin_acceptor #(
  parameter int PRICE    = 10,
  parameter int CREDIT_W = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  coin_acceptor_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT,
    CHANGE,
    PAID,
    REFUND
  } state_t;

  localparam logic [CREDIT_W:0]   PRICE_S =
    (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C =
    CREDIT_W'(PRICE);

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] count_q;
  logic                reject_q;

  logic [3:0]          val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   diff;
  logic                coin_any;
  logic                ret;

  always_comb begin
    val = {3'b000, bus.i_coin_1}
        + {2'b00, bus.i_coin_2, 1'b0}
        + (bus.i_coin_5 ? 4'd5 : 4'd0);
    // One extra bit so credit + coin value never wraps.
    sum = {1'b0, credit_q}
        + {{(CREDIT_W-3){1'b0}}, val};
    diff = sum - PRICE_S;
    coin_any = bus.i_coin_1
             | bus.i_coin_2
             | bus.i_coin_5;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      // Coins are only credited while collecting.
      reject_q <= coin_any
                & (state_q != COLLECT);
      unique case (state_q)
        COLLECT: begin
          if (bus.i_cancel) begin
            credit_q <= '0;
            if (sum != '0) begin
              state_q <= REFUND;
              count_q <= sum[CREDIT_W-1:0];
            end
          end else if (sum > PRICE_S) begin
            state_q  <= CHANGE;
            count_q  <= diff[CREDIT_W-1:0];
            credit_q <= '0;
          end else if (sum == PRICE_S) begin
            state_q  <= PAID;
            credit_q <= '0;
          end else begin
            credit_q <= sum[CREDIT_W-1:0];
          end
        end
        CHANGE: begin
          count_q <= count_q - 1'b1;
          if (count_q == CREDIT_W'(1))
            state_q <= PAID;
        end
        PAID: begin
          if (bus.i_cycle_done) begin
            state_q  <= COLLECT;
            credit_q <= '0;
          end else if (bus.i_coinreturn) begin
            state_q <= REFUND;
            count_q <= PRICE_C;
          end
        end
        REFUND: begin
          count_q <= count_q - 1'b1;
          if (count_q == CREDIT_W'(1)) begin
            state_q  <= COLLECT;
            credit_q <= '0;
          end
        end
      endcase
    end
  end

  // Outputs decode from registers only.
  assign ret = (state_q == CHANGE)
             | (state_q == REFUND);

  assign bus.o_coin   = (state_q == PAID);
  assign bus.o_change = ret;
  assign bus.o_busy   = ret;
  assign bus.o_reject = reject_q;

  always_comb begin
    bus.o_credit = credit_q;
    unique case (1'b1)
      (state_q == PAID): bus.o_credit = PRICE_C;
      ret:               bus.o_credit = count_q;
      default:           bus.o_credit = credit_q;
    endcase
  end

endmodule
